dmem_arbiter: RTL

Shares a single data-memory port between the CPU load/store path and the convolution accelerator. The CPU gets fixed priority, with two exceptions: the accelerator is guaranteed service after bounded starvation, and it may lock the port for atomic bursts of bounded length. The block sits between the memory-mapped I/O / conv logic and the synchronous (1-cycle read latency) data memory, and returns read data to the requester that issued it.

---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates one synchronous data-memory port between the CPU and the conv accelerator.
// CPU has fixed priority, bounded by accelerator starvation relief and capped lock bursts.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned LOCK_MAX     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_we,
    input  logic [31:0] cpu_din,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        acc_req,
    input  logic [31:0] acc_addr,
    input  logic [3:0]  acc_we,
    input  logic [31:0] acc_din,
    input  logic        acc_lock,
    output logic        acc_gnt,
    output logic        acc_rvalid,
    output logic [31:0] acc_rdata,
    output logic        mem_en,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    output logic        locked
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);

    localparam logic [1:0] ST_ARB    = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_YIELD  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          rd_cpu_q, rd_acc_q;
    logic          starve_sat, lock_sat;

    assign starve_sat = (starve_q == SW'(STARVE_LIMIT));
    assign lock_sat   = (lock_q == LW'(LOCK_MAX));

    // State, counter and grant decision; grants are same-cycle combinational.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        cpu_gnt = 1'b0;
        acc_gnt = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (acc_req && starve_sat) begin
                    acc_gnt = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt = 1'b1;
                end else if (acc_req) begin
                    acc_gnt = 1'b1;
                end
                if (acc_gnt && acc_lock) begin
                    state_d = ST_LOCKED;
                    lock_d  = LW'(1);
                end
            end
            ST_LOCKED: begin
                if (!acc_lock) begin
                    // Lock released: a pending unlocked access is served as a normal one.
                    acc_gnt = acc_req;
                    state_d = ST_ARB;
                    lock_d  = '0;
                end else if (lock_sat && cpu_req) begin
                    state_d = ST_YIELD;
                end else begin
                    acc_gnt = acc_req;
                    if (acc_req && !lock_sat) begin
                        lock_d = lock_q + LW'(1);
                    end
                end
            end
            ST_YIELD: begin
                cpu_gnt = cpu_req;
                lock_d  = '0;
                state_d = acc_lock ? ST_LOCKED : ST_ARB;
            end
            default: begin
                state_d = ST_ARB;
                lock_d  = '0;
            end
        endcase
    end

    always_comb begin
        starve_d = '0;
        if (acc_req && !acc_gnt) begin
            starve_d = starve_sat ? starve_q : starve_q + SW'(1);
        end
    end

    // Port mux; idle cycles leave the CPU payload on the bus with writes disabled.
    always_comb begin
        mem_en   = cpu_gnt | acc_gnt;
        mem_addr = acc_gnt ? acc_addr : cpu_addr;
        mem_din  = acc_gnt ? acc_din : cpu_din;
        mem_we   = 4'b0;
        if (acc_gnt) begin
            mem_we = acc_we;
        end else if (cpu_gnt) begin
            mem_we = cpu_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_ARB;
            starve_q <= '0;
            lock_q   <= '0;
            rd_cpu_q <= 1'b0;
            rd_acc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            lock_q   <= lock_d;
            rd_cpu_q <= cpu_gnt && (cpu_we == 4'b0);
            rd_acc_q <= acc_gnt && (acc_we == 4'b0);
        end
    end

    assign cpu_rvalid = rd_cpu_q;
    assign acc_rvalid = rd_acc_q;
    assign cpu_rdata  = mem_dout;
    assign acc_rdata  = mem_dout;
    assign locked     = (state_q == ST_LOCKED);

endmodule
